plru_tree_array: RTL

PLRU_TREE_ARRAY -- requirements
Module: plru_tree_array

---
 rtl/plru_tree_array_pkg.sv | 32 +++
 rtl/plru_tree_array_logic.sv | 58 +++++
 rtl/plru_tree_array.sv | 91 +++++++++
 3 files changed

// File: rtl/plru_tree_array_pkg.sv
// Shared cache-replacement types: default PLRU geometry, the legacy 4-way
// encodings and the heap-ordered tree-node index helpers.
package rv32im_types;

  localparam int PLRU_NUM_WAYS = 4;
  localparam int PLRU_NUM_SETS = 16;

  typedef enum logic [1:0] {
    WAY0 = 2'd0,
    WAY1 = 2'd1,
    WAY2 = 2'd2,
    WAY3 = 2'd3
  } way4_e;

  // Legacy 4-way tree {node2, node1, node0}; all-zero selects WAY3.
  localparam logic [2:0] PLRU4_TREE_RESET  = 3'b000;
  localparam way4_e      PLRU4_RESET_VICTIM = WAY3;

  // Heap order: children of node n are 2n+1 (lower half) and 2n+2 (upper half).
  function automatic int node_child(input int node, input logic upper);
    return 2 * node + 1 + int'(upper);
  endfunction

  function automatic int node_parent(input int node);
    return (node - 1) / 2;
  endfunction

  function automatic int tree_nodes(input int nways);
    return nways - 1;
  endfunction

endpackage

// File: rtl/plru_tree_array_logic.sv
// Combinational PLRU tree functions: next tree after an access, and the
// victim selected by walking a tree from the root.
module plru_tree_logic
  import rv32im_types::*;
#(
  parameter  int NUM_WAYS = PLRU_NUM_WAYS,
  localparam int WAY_W    = $clog2(NUM_WAYS),
  localparam int NODES    = NUM_WAYS - 1
) (
  input  logic [NODES-1:0] upd_tree,
  input  logic [WAY_W-1:0] upd_way,
  output logic [NODES-1:0] upd_next,
  input  logic [NODES-1:0] vic_tree,
  output logic [WAY_W-1:0] vic_way
);

  // Trees are padded to NUM_WAYS bits so a WAY_W-bit node index always fits.
  logic [NUM_WAYS-1:0] upd_ext;
  logic [WAY_W-1:0]    upd_idx;
  logic [WAY_W-1:0]    upd_rem;
  logic                upd_bit;

  logic [NUM_WAYS-1:0] vic_ext;
  logic [WAY_W-1:0]    vic_idx;
  logic [WAY_W-1:0]    vic_acc;
  logic                vic_go;

  // Each on-path node points away from the accessed way; way bits are
  // consumed MSB first, one per tree level.
  always_comb begin
    upd_ext = {1'b0, upd_tree};
    upd_idx = '0;
    upd_rem = upd_way;
    upd_bit = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      upd_bit          = upd_rem[WAY_W-1];
      upd_ext[upd_idx] = upd_bit;
      upd_rem          = upd_rem << 1;
      upd_idx          = WAY_W'(node_child(int'(upd_idx), upd_bit));
    end
    upd_next = upd_ext[NODES-1:0];
  end

  // Node bit 0 sends the walk to the upper half, so the step direction is ~bit.
  always_comb begin
    vic_ext = {1'b0, vic_tree};
    vic_idx = '0;
    vic_acc = '0;
    vic_go  = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      vic_go  = ~vic_ext[vic_idx];
      vic_acc = (vic_acc << 1) | WAY_W'(vic_go);
      vic_idx = WAY_W'(node_child(int'(vic_idx), vic_go));
    end
    vic_way = vic_acc;
  end

endmodule

// File: rtl/plru_tree_array.sv
// Per-set tree-PLRU state in flops, with same-cycle update bypass,
// invalid-way priority and a registered victim output.
module plru_tree_array
  import rv32im_types::*;
#(
  parameter  int NUM_WAYS = PLRU_NUM_WAYS,
  parameter  int NUM_SETS = PLRU_NUM_SETS,
  localparam int WAY_W    = $clog2(NUM_WAYS),
  localparam int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_valid,
  input  logic [SET_W-1:0]    lookup_set,
  input  logic [NUM_WAYS-1:0] valid_mask,
  input  logic                update_valid,
  input  logic [SET_W-1:0]    update_set,
  input  logic [WAY_W-1:0]    update_way,
  output logic                victim_valid,
  output logic [WAY_W-1:0]    victim_way
);

  localparam int NODES = NUM_WAYS - 1;
  // With a single set the 1-bit index still addresses two entries.
  localparam int DEPTH = 1 << SET_W;

  logic [NODES-1:0] trees [DEPTH];

  logic [NODES-1:0] upd_cur;
  logic [NODES-1:0] upd_next;
  logic [NODES-1:0] look_tree;
  logic [WAY_W-1:0] tree_way;
  logic             same_set;

  logic [NUM_WAYS-1:0] inv_scan;
  logic [WAY_W-1:0]    inv_way;
  logic                inv_found;
  logic [WAY_W-1:0]    sel_way;

  assign upd_cur   = trees[update_set];
  assign same_set  = update_valid && (update_set == lookup_set);
  // Bypass: a lookup to the set being written sees the post-update tree.
  assign look_tree = same_set ? upd_next : trees[lookup_set];

  plru_tree_logic #(
    .NUM_WAYS (NUM_WAYS)
  ) u_logic (
    .upd_tree (upd_cur),
    .upd_way  (update_way),
    .upd_next (upd_next),
    .vic_tree (look_tree),
    .vic_way  (tree_way)
  );

  // Lowest-index invalid way; ignored when every way is valid.
  always_comb begin
    inv_scan  = valid_mask;
    inv_way   = '0;
    inv_found = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!inv_found) begin
        if (!inv_scan[0]) begin
          inv_found = 1'b1;
        end else begin
          inv_way = inv_way + WAY_W'(1);
        end
      end
      inv_scan = inv_scan >> 1;
    end
    sel_way = inv_found ? inv_way : tree_way;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) begin
        trees[d] <= '0;
      end
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      if (update_valid) begin
        trees[update_set] <= upd_next;
      end
      victim_valid <= lookup_valid;
      if (lookup_valid) begin
        victim_way <= sel_way;
      end
    end
  end

endmodule
